seq_scan_ctrl: RTL and testbench
================================

// Module: seq_scan_ctrl
// PURPOSE
// Front-end sequencer for the '101' Mealy sequence detector. Takes parallel data words over a
// valid/ready handshake and serialises each word MSB-first, one bit per clock, onto the
// detector's x input. It samples the detector's z output in the same cycle, counts matches
// against a programmable limit, and clears the detector between non-contiguous words.
// PARAMETERS
// DATA_W  8  width of each input word, in bits (>=2)
// CNT_W   8  width of the match counter and of the limit input
// PORTS
// clk        in   1       system clock; every flop updates on posedge
// rst        in   1       asynchronous reset, active-low
// start      in   1       1-cycle pulse; starts a scan run (honoured in IDLE/DONE only)
// abort      in   1       1-cycle pulse; ends the run now, checked in every state
// limit      in   CNT_W   match count that ends the run; 0 = unlimited; sampled on start
// in_data    in   DATA_W  word to serialise
// in_valid   in   1       in_data is valid
// in_ready   out  1       controller accepts in_data this cycle
// det_x      out  1       serial bit to the detector x input
// det_rst_n  out  1       registered active-low reset to the detector
// det_z      in   1       detector Mealy output; combinational from det_x
// hit        out  1       det_z seen while a bit was being shifted (1-cycle pulse)
// match_cnt  out  CNT_W   matches counted since the last start
// busy       out  1       1 in CLR/WAIT/SHIFT
// done       out  1       1 while in DONE (limit reached)
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset values: state=IDLE, match_cnt=0, det_rst_n=0, all other outputs 0.
// - States are IDLE, CLR, WAIT, SHIFT and DONE.
//   IDLE/DONE: start -> CLR. The lim register loads from limit and match_cnt clears.
//   CLR: one cycle, then -> WAIT.
//   WAIT: in_ready=1. If in_valid is high: load sreg<=in_data, set bit_idx<=DATA_W-1, -> SHIFT.
//   SHIFT: det_x=sreg[DATA_W-1]. Each cycle sreg shifts left by 1 and bit_idx decrements.
// - On the last bit of a word (bit_idx==0), in_ready=1.
//   If in_valid is high, the next word loads and the state stays SHIFT with no bubble.
//   Otherwise -> WAIT.
// - det_rst_n is registered. It is 1 in the cycle after each SHIFT cycle that does not leave
//   SHIFT, and 0 in every other cycle.
//   The detector is therefore held in s0 throughout IDLE, CLR, WAIT and DONE.
//   Patterns that span a word boundary are detected only when the words are back-to-back.
// - Outside SHIFT: det_x=0, and det_z is ignored.
// - In SHIFT, when det_z=1: hit=1 in that same cycle, and match_cnt increments at the edge,
//   saturating at 2^CNT_W-1.
// - If lim!=0 and match_cnt+1==lim on a hit: -> DONE at that edge. The rest of the word is
//   dropped and no further words are accepted.
// - With lim=0 the run never ends on its own; only abort ends it.
// - abort (priority over start and in_valid): -> IDLE next edge, in_ready=0 in that cycle.
//   match_cnt is held and done=0. A hit in the abort cycle is still counted.
// - start while busy is ignored.
// - Reset mid-word drops the word, clears the count and holds the detector in reset.
// - DONE holds until start or abort. match_cnt is held there.
// TESTING
// - limit=0, start, 8'hA5 -> hit in SHIFT cycles 3 and 8; match_cnt=2; then WAIT.
// - limit=0, 8'h55 -> hits in SHIFT cycles 4, 6 and 8 (overlap); match_cnt=3.
// - 8'h02 then 8'h80, back-to-back -> hit on the 1st bit of word 2, match_cnt=1.
//   Same words with a 1-cycle bubble -> match_cnt=0.
// - limit=2, 8'h55 -> DONE after SHIFT cycle 6; match_cnt=2; done=1; in_ready=0.
// - abort in SHIFT cycle 4 of 8'hA5 -> IDLE next cycle, match_cnt=1, det_rst_n=0, done=0.
// - rst low mid-SHIFT -> all outputs at reset values immediately. 8'hFF -> match_cnt=0.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Serialiser front-end for a '101' Mealy detector: accepts words over valid/ready,
// shifts them MSB-first onto det_x, and counts det_z matches against a programmable limit.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  limit,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              det_x,
  output logic              det_rst_n,
  input  logic              det_z,
  output logic              hit,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state, w_next;
  logic [DATA_W-1:0]  r_sreg, w_sreg_nxt;
  logic [IDX_W-1:0]   r_bit_idx, w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_lim, w_lim_nxt;
  logic               r_det_rst_n, w_drn_nxt;
  logic               w_shift, w_hit, w_lim_hit;

  assign w_shift   = (r_state == S_SHIFT);
  assign w_hit     = w_shift & det_z;
  // Compare is CNT_W wide, so a saturated counter never matches a nonzero limit.
  assign w_lim_hit = w_hit && (r_lim != '0) && ((r_cnt + CNT_W'(1)) == r_lim);

  assign det_x     = w_shift & r_sreg[DATA_W-1];
  assign hit       = w_hit;
  assign match_cnt = r_cnt;
  assign det_rst_n = r_det_rst_n;
  assign busy      = (r_state == S_CLR) || (r_state == S_WAIT) || (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);

  always_comb begin
    w_next     = r_state;
    w_sreg_nxt = r_sreg;
    w_idx_nxt  = r_bit_idx;
    w_cnt_nxt  = r_cnt;
    w_lim_nxt  = r_lim;
    w_drn_nxt  = 1'b0;
    in_ready   = 1'b0;

    if (w_hit && !(&r_cnt)) w_cnt_nxt = r_cnt + CNT_W'(1);

    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_next    = S_CLR;
            w_lim_nxt = limit;
            w_cnt_nxt = '0;
          end
        end
        S_CLR: w_next = S_WAIT;
        S_WAIT: begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_sreg_nxt = in_data;
            w_idx_nxt  = IDX_W'(DATA_W-1);
            w_next     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_lim_hit) begin
            w_next = S_DONE;
          end else begin
            w_sreg_nxt = r_sreg << 1;
            w_idx_nxt  = r_bit_idx - IDX_W'(1);
            // Detector keeps running only while shifting stays contiguous.
            w_drn_nxt  = 1'b1;
            if (r_bit_idx == '0) begin
              in_ready = 1'b1;
              if (in_valid) begin
                w_sreg_nxt = in_data;
                w_idx_nxt  = IDX_W'(DATA_W-1);
              end else begin
                w_next    = S_WAIT;
                w_drn_nxt = 1'b0;
              end
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_lim       <= '0;
      r_det_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_sreg      <= w_sreg_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lim       <= w_lim_nxt;
      r_det_rst_n <= w_drn_nxt;
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: a '101' detector stand-in, a bit-queue reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_seq_scan_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [CNT_W-1:0]  limit = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, det_x, det_rst_n, det_z, hit, busy, done;
  logic [CNT_W-1:0]  match_cnt;

  int errors = 0;
  int checks = 0;

  seq_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .limit(limit),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .det_x(det_x),
    .det_rst_n(det_rst_n), .det_z(det_z), .hit(hit), .match_cnt(match_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Detector stand-in: overlapping '101' Mealy; its reset gates the state seen by z.
  logic [1:0] d_s = 2'd0;
  logic [1:0] d_eff;
  always_comb begin
    d_eff = det_rst_n ? d_s : 2'd0;
    det_z = (d_eff == 2'd2) && det_x;
  end
  always @(posedge clk) begin
    case (d_eff)
      2'd0:    d_s <= det_x ? 2'd1 : 2'd0;
      2'd1:    d_s <= det_x ? 2'd1 : 2'd2;
      default: d_s <= det_x ? 2'd1 : 2'd0;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending bits of the current word, detector input history since clear.
  bit               m_bits[$];
  bit               m_run = 0, m_clr = 0, m_done = 0, m_drn = 0;
  int               m_cnt = 0, m_lim = 0, hlen = 0;
  logic [1:0]       h2 = 2'b00;
  logic [DATA_W-1:0] hitmask = '0;

  always @(negedge clk) begin : model
    bit shifting, e_x, e_hit, lim_end, e_rdy, nd;
    if (!rst) begin
      m_bits.delete();
      m_run = 0; m_clr = 0; m_done = 0; m_drn = 0;
      m_cnt = 0; m_lim = 0; hlen = 0; h2 = 2'b00; hitmask = '0;
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_x", int'(det_x), 0);
      chk("rst_drn", int'(det_rst_n), 0);
      chk("rst_hit", int'(hit), 0);
      chk("rst_cnt", int'(match_cnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end else begin
      shifting = (m_bits.size() != 0);
      e_x      = shifting ? m_bits[0] : 1'b0;
      e_hit    = shifting && e_x && m_drn && (hlen >= 2) && (h2 == 2'b10);
      lim_end  = e_hit && (m_lim != 0) && (m_cnt + 1 == m_lim);
      e_rdy    = !abort && m_run && !m_clr && (!shifting || (m_bits.size() == 1 && !lim_end));
      chk("in_ready", int'(in_ready), int'(e_rdy));
      chk("det_x", int'(det_x), int'(e_x));
      chk("det_rst_n", int'(det_rst_n), int'(m_drn));
      chk("hit", int'(hit), int'(e_hit));
      chk("match_cnt", int'(match_cnt), m_cnt);
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));

      if (e_hit) hitmask[DATA_W - m_bits.size()] = 1'b1;
      if (m_drn) begin h2 = {h2[0], e_x}; hlen++; end
      else begin h2 = {1'b0, e_x}; hlen = 1; end
      if (e_hit && m_cnt < MAXC) m_cnt++;

      nd = 0;
      if (abort) begin
        m_run = 0; m_done = 0; m_clr = 0; m_bits.delete();
      end else if (!m_run) begin
        if (start) begin
          m_run = 1; m_clr = 1; m_done = 0; m_lim = int'(limit); m_cnt = 0;
        end
      end else if (m_clr) begin
        m_clr = 0;
      end else if (lim_end) begin
        m_run = 0; m_done = 1; m_bits.delete();
      end else begin
        if (shifting) begin
          void'(m_bits.pop_front());
          nd = (m_bits.size() != 0) || in_valid;
        end
        if (m_bits.size() == 0 && in_valid) begin
          for (int b = DATA_W-1; b >= 0; b--) m_bits.push_back(in_data[b]);
          hitmask = '0;
        end
      end
      m_drn = nd;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic restart(input logic [CNT_W-1:0] lim);
    abort = 1'b1; cyc(1); abort = 1'b0;
    start = 1'b1; limit = lim; cyc(1); start = 1'b0;
  endtask

  // Presents a word until accepted; returns one step into the first shift cycle.
  task automatic send(input logic [DATA_W-1:0] d, input bit keep);
    bit acc;
    acc = 0;
    in_data = d; in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    if (!keep) in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    cyc(3);
    chk("por_cnt", int'(match_cnt), 0);
    chk("por_drn", int'(det_rst_n), 0);
    rst = 1'b1;
    cyc(1);

    restart(0); send(8'hA5, 0); cyc(8);
    chk("a5_cnt", int'(match_cnt), 2);
    chk("a5_mask", int'(hitmask), 8'h84);
    chk("a5_wait", int'({busy, in_ready}), 3);

    restart(0); send(8'h55, 0); cyc(8);
    chk("55_cnt", int'(match_cnt), 3);
    chk("55_mask", int'(hitmask), 8'hA8);

    restart(0); send(8'h02, 1); send(8'h80, 0); cyc(8);
    chk("b2b_cnt", int'(match_cnt), 1);
    chk("b2b_mask", int'(hitmask), 8'h01);

    restart(0); send(8'h02, 0); cyc(12); send(8'h80, 0); cyc(8);
    chk("bubble_cnt", int'(match_cnt), 0);

    restart(2); send(8'h55, 0); cyc(8);
    chk("lim_done", int'(done), 1);
    chk("lim_cnt", int'(match_cnt), 2);
    chk("lim_mask", int'(hitmask), 8'h28);
    in_data = 8'hA5; in_valid = 1'b1; cyc(3);
    chk("lim_ready", int'(in_ready), 0);
    chk("lim_busy", int'(busy), 0);
    chk("lim_hold", int'(match_cnt), 2);
    in_valid = 1'b0;

    restart(0); send(8'hA5, 0); cyc(3);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_cnt", int'(match_cnt), 1);
    chk("abort_drn", int'(det_rst_n), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);

    restart(0); send(8'hFF, 0); cyc(2);
    rst = 1'b0; #1;
    chk("arst_all", int'({in_ready, det_x, det_rst_n, hit, busy, done}), 0);
    chk("arst_cnt", int'(match_cnt), 0);
    @(posedge clk); #1; rst = 1'b1;
    restart(0); send(8'hFF, 0); cyc(8);
    chk("ff_cnt", int'(match_cnt), 0);

    restart(0); in_data = 8'h55; in_valid = 1'b1; cyc(660);
    in_valid = 1'b0; cyc(10);
    chk("sat_cnt", int'(match_cnt), MAXC);

    for (int i = 0; i < 2500; i++) begin
      start    = ($urandom % 16) == 0;
      abort    = ($urandom % 50) == 0;
      limit    = CNT_W'($urandom % 5);
      in_valid = ($urandom % 3) != 0;
      in_data  = DATA_W'($urandom);
      rst      = ($urandom % 400) != 0;
      cyc(1);
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
